// File: rtl/text_term_if.sv
// Keyboard handshake, video-memory write port and cursor/scroll status of the text terminal.
// The controller takes the slave side; the keyboard/VGA environment takes the master side.
interface text_term_if;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        key_ready;
  logic        clr_req;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  scroll_row;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  modport master (
    output key_valid, key_ascii, clr_req,
    input  key_ready, wr_en, wr_addr, wr_data, scroll_row, cur_col, cur_row, busy
  );

  modport slave (
    input  key_valid, key_ascii, clr_req,
    output key_ready, wr_en, wr_addr, wr_data, scroll_row, cur_col, cur_row, busy
  );
endinterface

// File: rtl/text_term_ctrl.sv
// Cursor and write sequencer for the character video memory: printable output, newline,
// backspace, line wrap, ring-buffer scrolling with bottom-line scrub, and full-screen clear.
module text_term_ctrl #(
  parameter int unsigned COLS  = 70,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  text_term_if.slave bus
);

  localparam logic [6:0] LAST_COL   = 7'(COLS - 1);
  localparam logic [6:0] SWEEP_DONE = 7'(COLS);
  localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LSCRUB = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        clr_pend_r, clr_pend_s;
  logic [6:0]  col_r, col_s;
  logic [4:0]  row_r, row_s;
  logic [4:0]  scroll_r, scroll_s;
  logic [6:0]  sw_col_r, sw_col_s;
  logic [4:0]  sw_row_r, sw_row_s;
  logic        wr_en_r, wr_en_s;
  logic [11:0] wr_addr_r, wr_addr_s;
  logic [7:0]  wr_data_r, wr_data_s;

  logic        is_print_s;
  logic        is_nl_s;
  logic        is_bs_s;
  logic [4:0]  cur_prow_s;
  logic [4:0]  up_prow_s;

  // Logical row to physical row through the ring offset; the 6-bit sum never exceeds 58.
  function automatic logic [4:0] phys_row(input logic [4:0] row, input logic [4:0] scroll);
    logic [5:0] sum;
    sum = {1'b0, row} + {1'b0, scroll};
    return (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
  endfunction

  function automatic logic [4:0] scroll_inc(input logic [4:0] scroll);
    return (scroll == LAST_ROW) ? 5'd0 : scroll + 5'd1;
  endfunction

  function automatic logic [11:0] vmem_addr(input logic [6:0] col, input logic [4:0] prow);
    return {col, prow};
  endfunction

  assign is_print_s = (bus.key_ascii >= PRINT_LO) && (bus.key_ascii <= PRINT_HI);
  assign is_nl_s    = (bus.key_ascii == ASCII_LF) || (bus.key_ascii == ASCII_CR);
  assign is_bs_s    = (bus.key_ascii == ASCII_BS);
  assign cur_prow_s = phys_row(row_r, scroll_r);
  assign up_prow_s  = phys_row(row_r - 5'd1, scroll_r);

  assign bus.key_ready  = (state_r == ST_IDLE) && !clr_pend_r;
  assign bus.busy       = (state_r != ST_IDLE) || clr_pend_r;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.scroll_row = scroll_r;
  assign bus.cur_col    = col_r;
  assign bus.cur_row    = row_r;

  // Next-state, cursor, sweep counter and write-port decisions.
  always_comb begin
    state_s    = state_r;
    clr_pend_s = clr_pend_r;
    col_s      = col_r;
    row_s      = row_r;
    scroll_s   = scroll_r;
    sw_col_s   = sw_col_r;
    sw_row_s   = sw_row_r;
    wr_en_s    = 1'b0;
    wr_addr_s  = wr_addr_r;
    wr_data_s  = wr_data_r;

    case (state_r)
      ST_IDLE: begin
        if (clr_pend_r) begin
          // The first blank goes out on the entry edge, so the sweep counter starts at column 1.
          state_s    = ST_CLEAR;
          clr_pend_s = 1'b0;
          col_s      = 7'd0;
          row_s      = 5'd0;
          scroll_s   = 5'd0;
          sw_col_s   = 7'd1;
          sw_row_s   = 5'd0;
          wr_en_s    = 1'b1;
          wr_addr_s  = vmem_addr(7'd0, 5'd0);
          wr_data_s  = BLANK;
        end else begin
          clr_pend_s = bus.clr_req;
          if (bus.key_valid) begin
            if (is_print_s) begin
              wr_en_s   = 1'b1;
              wr_addr_s = vmem_addr(col_r, cur_prow_s);
              wr_data_s = bus.key_ascii;
              if (col_r < LAST_COL) begin
                col_s = col_r + 7'd1;
              end else begin
                col_s = 7'd0;
                if (row_r < LAST_ROW) begin
                  row_s = row_r + 5'd1;
                end else begin
                  // Write slot is taken by the character, so the scrub starts next cycle.
                  scroll_s = scroll_inc(scroll_r);
                  state_s  = ST_LSCRUB;
                  sw_col_s = 7'd0;
                  sw_row_s = scroll_r;
                end
              end
            end else if (is_nl_s) begin
              col_s = 7'd0;
              if (row_r < LAST_ROW) begin
                row_s = row_r + 5'd1;
              end else begin
                scroll_s  = scroll_inc(scroll_r);
                state_s   = ST_LSCRUB;
                sw_col_s  = 7'd1;
                sw_row_s  = scroll_r;
                wr_en_s   = 1'b1;
                wr_addr_s = vmem_addr(7'd0, scroll_r);
                wr_data_s = BLANK;
              end
            end else if (is_bs_s) begin
              if (col_r != 7'd0) begin
                col_s     = col_r - 7'd1;
                wr_en_s   = 1'b1;
                wr_addr_s = vmem_addr(col_r - 7'd1, cur_prow_s);
                wr_data_s = BLANK;
              end else if (row_r != 5'd0) begin
                row_s     = row_r - 5'd1;
                col_s     = LAST_COL;
                wr_en_s   = 1'b1;
                wr_addr_s = vmem_addr(LAST_COL, up_prow_s);
                wr_data_s = BLANK;
              end else begin
                col_s = col_r;
              end
            end else begin
              wr_en_s = 1'b0;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end
      end

      ST_CLEAR: begin
        // Requests arriving mid-sweep merge into the clear already running.
        if (sw_col_r == SWEEP_DONE) begin
          state_s = ST_IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = vmem_addr(sw_col_r, sw_row_r);
          wr_data_s = BLANK;
          if (sw_col_r != LAST_COL) begin
            sw_col_s = sw_col_r + 7'd1;
          end else if (sw_row_r != LAST_ROW) begin
            sw_col_s = 7'd0;
            sw_row_s = sw_row_r + 5'd1;
          end else begin
            sw_col_s = SWEEP_DONE;
          end
        end
      end

      ST_LSCRUB: begin
        clr_pend_s = clr_pend_r | bus.clr_req;
        if (sw_col_r == SWEEP_DONE) begin
          state_s = ST_IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = vmem_addr(sw_col_r, sw_row_r);
          wr_data_s = BLANK;
          sw_col_s  = sw_col_r + 7'd1;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, cursor and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      clr_pend_r <= 1'b1;
      col_r      <= 7'd0;
      row_r      <= 5'd0;
      scroll_r   <= 5'd0;
      sw_col_r   <= 7'd0;
      sw_row_r   <= 5'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= 12'd0;
      wr_data_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      clr_pend_r <= clr_pend_s;
      col_r      <= col_s;
      row_r      <= row_s;
      scroll_r   <= scroll_s;
      sw_col_r   <= sw_col_s;
      sw_row_r   <= sw_row_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Bench for text_term_ctrl: directed scenarios plus random keys, all checked every cycle
// against a queue-of-expected-writes model of the terminal rules.
module tb_text_term_ctrl;

  logic clk;
  logic rst;

  text_term_if bus ();

  text_term_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          v;
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  // Model: each queue entry is what the write port must show in one future cycle.
  wr_t         m_q[$];
  int          m_col;
  int          m_row;
  int          m_scroll;
  bit          m_pend;
  bit          m_in_clear;
  bit          exp_en;
  logic [11:0] exp_addr;
  logic [7:0]  exp_data;

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic push_wr(input int c, input int prow, input logic [7:0] d);
    wr_t e;
    e.v = 1'b1;
    e.a = 12'(c * 32 + prow);
    e.d = d;
    m_q.push_back(e);
  endtask

  task automatic push_gap();
    wr_t e;
    e.v = 1'b0;
    e.a = 12'd0;
    e.d = 8'd0;
    m_q.push_back(e);
  endtask

  function automatic int prow_of(input int lrow);
    return (lrow + m_scroll) % 30;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_col      = 0;
    m_row      = 0;
    m_scroll   = 0;
    m_pend     = 1'b1;
    m_in_clear = 1'b0;
    exp_en     = 1'b0;
    exp_addr   = 12'd0;
    exp_data   = 8'd0;
  endtask

  task automatic model_newline();
    int old;
    m_col = 0;
    if (m_row < 29) begin
      m_row++;
    end else begin
      old      = m_scroll;
      m_scroll = (m_scroll + 1) % 30;
      for (int c = 0; c < 70; c++) push_wr(c, old, 8'h20);
      push_gap();
    end
  endtask

  task automatic model_key(input logic [7:0] k);
    if (k >= 8'h20 && k <= 8'h7E) begin
      push_wr(m_col, prow_of(m_row), k);
      if (m_col < 69) m_col++;
      else model_newline();
    end else if (k == 8'h0A || k == 8'h0D) begin
      model_newline();
    end else if (k == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_col, prow_of(m_row), 8'h20);
      end else if (m_row > 0) begin
        m_row--;
        m_col = 69;
        push_wr(m_col, prow_of(m_row), 8'h20);
      end
    end
  endtask

  task automatic model_step();
    bit  ready;
    wr_t e;
    ready = (m_q.size() == 0) && !m_pend;
    if (m_q.size() == 0 && m_pend) begin
      m_pend     = 1'b0;
      m_in_clear = 1'b1;
      m_col      = 0;
      m_row      = 0;
      m_scroll   = 0;
      for (int r = 0; r < 30; r++)
        for (int c = 0; c < 70; c++) push_wr(c, r, 8'h20);
      push_gap();
    end else begin
      if (!m_in_clear && bus.clr_req) m_pend = 1'b1;
      if (ready && bus.key_valid) model_key(bus.key_ascii);
    end
    if (m_q.size() > 0) begin
      e      = m_q.pop_front();
      exp_en = e.v;
      if (e.v) begin
        exp_addr = e.a;
        exp_data = e.d;
      end
    end else begin
      exp_en = 1'b0;
    end
    if (m_q.size() == 0) m_in_clear = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("key_ready", 32'(bus.key_ready), 32'((m_q.size() == 0) && !m_pend));
    check_val("busy", 32'(bus.busy), 32'((m_q.size() != 0) || m_pend));
    check_val("wr_en", 32'(bus.wr_en), 32'(exp_en));
    if (exp_en || !rst) begin
      check_val("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
      check_val("wr_data", 32'(bus.wr_data), 32'(exp_data));
    end
    check_val("cur_col", 32'(bus.cur_col), 32'(m_col));
    check_val("cur_row", 32'(bus.cur_row), 32'(m_row));
    check_val("scroll_row", 32'(bus.scroll_row), 32'(m_scroll));
  endtask

  // One clock: model consumes the inputs seen at the edge, DUT is compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (!bus.key_ready && cnt < 2300) begin
      tick();
      cnt++;
    end
    check_val(tag, 32'(bus.key_ready), 32'd1);
  endtask

  task automatic send_key(input logic [7:0] k);
    bit acc;
    int cnt;
    bus.key_valid = 1'b1;
    bus.key_ascii = k;
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 2500) begin
      acc = bus.key_ready;
      tick();
      cnt++;
    end
    check_val("key_accept", 32'(acc), 32'd1);
    bus.key_valid = 1'b0;
  endtask

  task automatic clear_screen();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    wait_ready("clear_done");
  endtask

  function automatic logic [7:0] rand_key();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 60) return 8'($urandom_range(32, 126));
    else if (sel < 66) return 8'h0A;
    else if (sel < 72) return 8'h0D;
    else if (sel < 90) return 8'h08;
    else if (sel < 95) return 8'($urandom_range(127, 255));
    else return 8'($urandom_range(0, 7));
  endfunction

  initial begin
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'd0;
    bus.clr_req   = 1'b0;
    model_reset();
    repeat (3) tick();
    #2 rst = 1'b1;
    wait_ready("reset_clear");

    // 'A','B' back to back, then carriage return.
    send_key(8'h41);
    send_key(8'h42);
    send_key(8'h0D);
    check_val("ab_cr_col", 32'(bus.cur_col), 32'd0);
    check_val("ab_cr_row", 32'(bus.cur_row), 32'd1);

    // Line wrap: 71 characters from the home position.
    clear_screen();
    for (int i = 0; i < 71; i++) send_key(8'h78);
    check_val("wrap_col", 32'(bus.cur_col), 32'd1);
    check_val("wrap_row", 32'(bus.cur_row), 32'd1);

    // Backspace at (0,0), at (0,1), and at (5,3).
    clear_screen();
    send_key(8'h08);
    check_val("bs_home_wr", 32'(bus.wr_en), 32'd0);
    send_key(8'h0A);
    send_key(8'h08);
    check_val("bs_up_addr", 32'(bus.wr_addr), 32'h8A0);
    check_val("bs_up_col", 32'(bus.cur_col), 32'd69);
    check_val("bs_up_row", 32'(bus.cur_row), 32'd0);
    repeat (3) send_key(8'h0A);
    repeat (5) send_key(8'h61);
    send_key(8'h08);
    check_val("bs_mid_addr", 32'(bus.wr_addr), 32'h083);
    check_val("bs_mid_col", 32'(bus.cur_col), 32'd4);

    // Thirty newlines force one scroll, then thirty more wrap the offset.
    clear_screen();
    repeat (30) send_key(8'h0A);
    check_val("scroll_once", 32'(bus.scroll_row), 32'd1);
    wait_ready("scrub_done");
    send_key(8'h5A);
    check_val("z_addr", 32'(bus.wr_addr), 32'h000);
    check_val("z_col", 32'(bus.cur_col), 32'd1);
    check_val("z_row", 32'(bus.cur_row), 32'd29);
    repeat (30) send_key(8'h0D);
    wait_ready("scroll_wrap_done");
    check_val("scroll_wrap", 32'(bus.scroll_row), 32'd1);

    // Clear request ahead of a waiting key: clear wins, the key lands after it.
    send_key(8'h31);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    send_key(8'h51);
    check_val("coll_col", 32'(bus.cur_col), 32'd1);
    check_val("coll_row", 32'(bus.cur_row), 32'd0);

    // Reset in the middle of a clear sweep.
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (500) tick();
    rst = 1'b0;
    #1;
    check_val("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("midrst_ready", 32'(bus.key_ready), 32'd0);
    check_val("midrst_busy", 32'(bus.busy), 32'd1);
    repeat (2) tick();
    #2 rst = 1'b1;
    wait_ready("midrst_clear");

    // Random traffic: keys with gaps, occasional clear requests outside a clear sweep.
    for (int i = 0; i < 4000; i++) begin
      bus.key_valid = ($urandom_range(0, 9) < 8);
      bus.key_ascii = rand_key();
      bus.clr_req   = (!m_in_clear && $urandom_range(0, 1499) == 0);
      tick();
    end
    bus.key_valid = 1'b0;
    bus.clr_req   = 1'b0;
    wait_ready("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
